// File: rtl/mem_copy_engine.sv
// Block-move (DMA) engine: copies LENGTH words from src to dst through the
// data_memory port, one READ cycle and one WRITE cycle per word.
// Optional fill mode (macro COPY_FILL_EN) writes a latched constant instead,
// skipping the READ cycles.
module mem_copy_engine #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic              fill_mode_i,
  input  logic [DATA_W-1:0] fill_value_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              memread_o,
  output logic              memwrite_o,
  input  logic [DATA_W-1:0] read_data_i
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              fill_q;
  logic [DATA_W-1:0] fill_val_q;

`ifdef COPY_FILL_EN
  logic              fill_d;
  logic [DATA_W-1:0] fill_val_d;
  logic              start_fill;
  assign start_fill = fill_mode_i;
`else
  // Fill ports exist but have no effect in copy-only builds.
  logic              unused_fill;
  logic              start_fill;
  assign unused_fill = ^{fill_mode_i, fill_value_i, fill_val_q};
  assign start_fill  = 1'b0;
  assign fill_q      = 1'b0;
  assign fill_val_q  = '0;
`endif

  // Next-state and next-output logic; outputs are precomputed for the next state.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
`ifdef COPY_FILL_EN
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d = src_addr_i;
          dst_d = dst_addr_i;
          cnt_d = length_i;
`ifdef COPY_FILL_EN
          fill_d     = fill_mode_i;
          fill_val_d = fill_value_i;
`endif
          if (length_i == LEN_W'(0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (start_fill) begin
            state_d = S_WRITE;
            busy_d  = 1'b1;
            wr_d    = 1'b1;
            addr_d  = dst_addr_i;
            wdata_d = fill_value_i;
          end else begin
            state_d = S_READ;
            busy_d  = 1'b1;
            rd_d    = 1'b1;
            addr_d  = src_addr_i;
          end
        end
      end
      S_READ: begin
        buf_d   = read_data_i;
        state_d = S_WRITE;
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        addr_d  = dst_q;
        wdata_d = read_data_i;
      end
      S_WRITE: begin
        src_d = src_q + STEP;
        dst_d = dst_q + STEP;
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (fill_q) begin
          state_d = S_WRITE;
          busy_d  = 1'b1;
          wr_d    = 1'b1;
          addr_d  = dst_q + STEP;
          wdata_d = fill_val_q;
        end else begin
          state_d = S_READ;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          addr_d  = src_q + STEP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

`ifdef COPY_FILL_EN
  // Fill mode and fill word, latched at start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else begin
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
    end
  end
`endif

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign addr_o       = addr_q;
  assign write_data_o = wdata_q;
  assign memread_o    = rd_q;
  assign memwrite_o   = wr_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a small data_memory model.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic        fill_mode;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memread;
  logic        memwrite;
  logic [31:0] read_data;
  logic        mem_init;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  int done_cyc, done_cnt, reads, writes, both_hi, busy_cnt;
  logic [31:0] addr_log [0:31];
  logic [31:0] wd_log   [0:31];
  logic [3:0]  snap_ctl;
  logic [31:0] snap_addr;
  logic [31:0] snap_wd;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .src_addr_i   (src_addr),
    .dst_addr_i   (dst_addr),
    .length_i     (length),
    .fill_mode_i  (fill_mode),
    .fill_value_i (fill_value),
    .busy_o       (busy),
    .done_o       (done),
    .addr_o       (addr),
    .write_data_o (write_data),
    .memread_o    (memread),
    .memwrite_o   (memwrite),
    .read_data_i  (read_data)
  );

  // data_memory: combinational read, write on clock edge, preload mem[k] = ~k.
  assign read_data = mem[addr[7:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= ~32'(k);
    end else if (memwrite) begin
      mem[addr[7:0]] <= write_data;
    end
  end

  task automatic init_mem();
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
  endtask

  // Start one operation and record per-cycle activity; cycle 1 follows the accepting edge.
  task automatic run_op(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                        input logic fm, input logic [31:0] fv,
                        input int rst_cyc, input int restart_cyc, input int max_cyc);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; fill_mode = fm; fill_value = fv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = 0; done_cnt = 0; reads = 0; writes = 0; both_hi = 0; busy_cnt = 0;
    snap_ctl = 4'hF; snap_addr = '1; snap_wd = '1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      addr_log[cyc] = addr;
      wd_log[cyc]   = write_data;
      if (memread && memwrite) both_hi++;
      if (memread) reads++;
      if (memwrite) writes++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        snap_ctl  = {busy, done, memread, memwrite};
        snap_addr = addr;
        snap_wd   = write_data;
      end
      rst   = (cyc == rst_cyc);
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        src_addr = 32'h0000_00F0; dst_addr = d + 32'd4; length = 16'd2;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (memread !== 1'b0) begin errors++; $display("FAIL reset_memread got %b exp 0", memread); end
    checks++; if (memwrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %b exp 0", memwrite); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
    checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", write_data); end
  endtask

  task automatic test_copy4();
    init_mem();
    run_op(32'h01, 32'h40, 16'd4, 1'b0, 32'h0, 0, 0, 14);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h40 + i] !== ~32'(1 + i)) begin
        errors++; $display("FAIL copy4_mem[%0d] got %h exp %h", 8'h40 + i, mem[8'h40 + i], ~32'(1 + i));
      end
    end
    checks++; if (mem[8'h44] !== ~32'h44) begin errors++; $display("FAIL copy4_beyond got %h exp %h", mem[8'h44], ~32'h44); end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL copy4_done_cycle got %0d exp 9", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL copy4_done_count got %0d exp 1", done_cnt); end
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL copy4_rw_overlap got %0d exp 0", both_hi); end
    checks++; if (reads !== 4 || writes !== 4) begin errors++; $display("FAIL copy4_accesses got r%0d w%0d exp r4 w4", reads, writes); end
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL copy4_busy_cycles got %0d exp 8", busy_cnt); end
    checks++; if (addr_log[1] !== 32'h01) begin errors++; $display("FAIL copy4_first_read_addr got %h exp 01", addr_log[1]); end
    checks++; if (addr_log[2] !== 32'h40 || wd_log[2] !== ~32'h01) begin
      errors++; $display("FAIL copy4_first_write got %h/%h exp 40/%h", addr_log[2], wd_log[2], ~32'h01);
    end
  endtask

  task automatic test_zero_length();
    init_mem();
    run_op(32'h05, 32'h60, 16'd0, 1'b0, 32'h0, 0, 0, 6);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_cnt); end
    checks++; if (reads !== 0 || writes !== 0) begin errors++; $display("FAIL zero_accesses got r%0d w%0d exp r0 w0", reads, writes); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL zero_busy got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_restart_ignored();
    init_mem();
    run_op(32'h08, 32'h50, 16'd4, 1'b0, 32'h0, 0, 3, 16);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", done_cnt); end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL restart_done_cycle got %0d exp 9", done_cyc); end
    checks++; if (mem[8'h54] !== ~32'h54) begin errors++; $display("FAIL restart_dst4 got %h exp %h", mem[8'h54], ~32'h54); end
    checks++; if (mem[8'h53] !== ~32'h0B) begin errors++; $display("FAIL restart_last got %h exp %h", mem[8'h53], ~32'h0B); end
  endtask

  task automatic test_reset_midcopy();
    init_mem();
    run_op(32'h10, 32'h80, 16'd8, 1'b0, 32'h0, 3, 0, 20);
    checks++; if (mem[8'h80] !== ~32'h10) begin errors++; $display("FAIL abort_first got %h exp %h", mem[8'h80], ~32'h10); end
    checks++; if (mem[8'h81] !== ~32'h81) begin errors++; $display("FAIL abort_second got %h exp %h", mem[8'h81], ~32'h81); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done_count got %0d exp 0", done_cnt); end
    checks++; if (snap_ctl !== 4'b0000) begin errors++; $display("FAIL abort_ctl got %b exp 0000", snap_ctl); end
    checks++; if (snap_addr !== 32'h0 || snap_wd !== 32'h0) begin
      errors++; $display("FAIL abort_bus got %h/%h exp 0/0", snap_addr, snap_wd);
    end
  endtask

  task automatic test_wrap();
    init_mem();
    run_op(32'hFFFF_FFFF, 32'h60, 16'd2, 1'b0, 32'h0, 0, 0, 8);
    checks++; if (addr_log[3] !== 32'h0) begin errors++; $display("FAIL wrap_src_addr got %h exp 0", addr_log[3]); end
    checks++; if (mem[8'h60] !== ~32'hFF) begin errors++; $display("FAIL wrap_word0 got %h exp %h", mem[8'h60], ~32'hFF); end
    checks++; if (mem[8'h61] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_word1 got %h exp ffffffff", mem[8'h61]); end
  endtask

  task automatic test_fill();
    init_mem();
`ifdef COPY_FILL_EN
    run_op(32'h00, 32'h20, 16'd3, 1'b1, 32'hDEAD_BEEF, 0, 0, 8);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[8'h20 + i] !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL fill_mem[%0d] got %h exp deadbeef", 8'h20 + i, mem[8'h20 + i]);
      end
    end
    checks++; if (mem[8'h23] !== ~32'h23) begin errors++; $display("FAIL fill_beyond got %h exp %h", mem[8'h23], ~32'h23); end
    checks++; if (reads !== 0) begin errors++; $display("FAIL fill_reads got %0d exp 0", reads); end
    checks++; if (done_cyc !== 4) begin errors++; $display("FAIL fill_done_cycle got %0d exp 4", done_cyc); end
`else
    run_op(32'h30, 32'h20, 16'd2, 1'b1, 32'hDEAD_BEEF, 0, 0, 8);
    checks++; if (mem[8'h20] !== ~32'h30) begin errors++; $display("FAIL nofill_word0 got %h exp %h", mem[8'h20], ~32'h30); end
    checks++; if (mem[8'h21] !== ~32'h31) begin errors++; $display("FAIL nofill_word1 got %h exp %h", mem[8'h21], ~32'h31); end
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL nofill_done_cycle got %0d exp 5", done_cyc); end
    checks++; if (reads !== 2) begin errors++; $display("FAIL nofill_reads got %0d exp 2", reads); end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_init = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_mode = 1'b0; fill_value = '0;
    test_reset();
    test_copy4();
    test_zero_length();
    test_restart_ignored();
    test_reset_midcopy();
    test_wrap();
    test_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
